// File: rtl/adder_pkg.sv
// Shared constants for the ripple-carry adder family.
//   ADDER_MAX_WIDTH : widest operand the adder accepts.
package adder_pkg;

    localparam int unsigned ADDER_MAX_WIDTH = 64;

endpackage : adder_pkg

// File: rtl/full_adder_bit.sv
// One-bit full-adder cell, purely combinational.
// Ports:
//   a, b  : operand bits
//   cin   : carry in
//   s     : sum bit
//   cout  : carry out
module full_adder_bit (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    logic p;

    // p is the propagate term; it is shared by the sum and the carry.
    assign p    = a ^ b;
    assign s    = p ^ cin;
    assign cout = (a & b) | (cin & p);

endmodule : full_adder_bit

// File: rtl/full_adder.sv
// WIDTH-bit ripple-carry adder: {Cout, S} = A + B + Cin.
// With REG_OUT=1 the results and valid are registered (1-cycle latency).
// With REG_OUT=0 the outputs are combinational and clk/rst_n are unused.
// Ports:
//   clk       : rising-edge clock
//   rst_n     : asynchronous active-low reset
//   in_valid  : A/B/Cin qualify this cycle
//   A, B      : operands
//   Cin       : carry into bit 0
//   out_valid : S/Cout hold a valid result
//   S         : sum
//   Cout      : carry out of the top bit
module full_adder
    import adder_pkg::*;
#(
    parameter int unsigned WIDTH   = 1,
    parameter bit          REG_OUT = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic             out_valid,
    output logic [WIDTH-1:0] S,
    output logic             Cout
);

    if (WIDTH < 1 || WIDTH > ADDER_MAX_WIDTH) begin : g_bad_width
        $error("full_adder: WIDTH=%0d outside 1..%0d", WIDTH, ADDER_MAX_WIDTH);
    end

    logic [WIDTH:0]   c;
    logic [WIDTH-1:0] sum;

    assign c[0] = Cin;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        full_adder_bit u_bit (
            .a    (A[i]),
            .b    (B[i]),
            .cin  (c[i]),
            .s    (sum[i]),
            .cout (c[i+1])
        );
    end

    if (REG_OUT) begin : g_reg
        logic [WIDTH-1:0] s_q;
        logic             cout_q;
        logic             valid_q;

        // Result only loads on a valid beat so the last sum is held while idle.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                s_q     <= '0;
                cout_q  <= 1'b0;
                valid_q <= 1'b0;
            end else begin
                valid_q <= in_valid;
                if (in_valid) begin
                    s_q    <= sum;
                    cout_q <= c[WIDTH];
                end
            end
        end

        assign S         = s_q;
        assign Cout      = cout_q;
        assign out_valid = valid_q;
    end else begin : g_comb
        logic unused_clk_rst;

        assign unused_clk_rst = clk ^ rst_n;
        assign S              = sum;
        assign Cout           = c[WIDTH];
        assign out_valid      = in_valid;
    end

endmodule : full_adder

// File: tb/tb_full_adder.sv
module tb_full_adder;

    logic clk;
    logic rst_n;

    // WIDTH=1, registered
    logic       v1, a1, b1, cin1, ov1, s1, co1;
    // WIDTH=8, registered
    logic       v8, cin8, ov8, co8;
    logic [7:0] a8, b8, s8;
    // WIDTH=4, combinational
    logic       v4, cin4, ov4, co4;
    logic [3:0] a4, b4, s4;
    // WIDTH=16, registered
    logic        v16, cin16, ov16, co16;
    logic [15:0] a16, b16, s16;

    int checks;
    int errors;

    full_adder #(.WIDTH(1), .REG_OUT(1'b1)) u_w1 (
        .clk(clk), .rst_n(rst_n), .in_valid(v1), .A(a1), .B(b1), .Cin(cin1),
        .out_valid(ov1), .S(s1), .Cout(co1)
    );

    full_adder #(.WIDTH(8), .REG_OUT(1'b1)) u_w8 (
        .clk(clk), .rst_n(rst_n), .in_valid(v8), .A(a8), .B(b8), .Cin(cin8),
        .out_valid(ov8), .S(s8), .Cout(co8)
    );

    full_adder #(.WIDTH(4), .REG_OUT(1'b0)) u_w4 (
        .clk(clk), .rst_n(rst_n), .in_valid(v4), .A(a4), .B(b4), .Cin(cin4),
        .out_valid(ov4), .S(s4), .Cout(co4)
    );

    full_adder #(.WIDTH(16), .REG_OUT(1'b1)) u_w16 (
        .clk(clk), .rst_n(rst_n), .in_valid(v16), .A(a16), .B(b16), .Cin(cin16),
        .out_valid(ov16), .S(s16), .Cout(co16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic a, b, cin;
        logic s, cout;
    } vec1_t;

    typedef struct {
        logic [7:0] a, b;
        logic       cin;
        logic [7:0] s;
        logic       cout;
    } vec8_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    vec1_t tv1[8];
    vec8_t tv8[3];

    initial begin
        logic [16:0] exp16;
        logic [15:0] held_s16;
        logic        held_c16;
        logic        exp_v16;

        checks = 0;
        errors = 0;

        // A B Cin -> S Cout
        tv1[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tv1[1] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        tv1[2] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        tv1[3] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        tv1[4] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        tv1[5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        tv1[6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        tv1[7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1};

        tv8[0] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
        tv8[1] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
        tv8[2] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};

        rst_n = 1'b1;
        {v1, a1, b1, cin1} = '0;
        {v8, a8, b8, cin8} = '0;
        {v4, a4, b4, cin4} = '0;
        {v16, a16, b16, cin16} = '0;

        #2 rst_n = 1'b0;
        #1;
        check("rst_w1_valid", 64'(ov1), 64'd0);
        check("rst_w1_s", 64'(s1), 64'd0);
        check("rst_w1_cout", 64'(co1), 64'd0);
        check("rst_w8_s", 64'(s8), 64'd0);
        check("rst_w16_valid", 64'(ov16), 64'd0);

        // Combinational instance ignores reset.
        a4 = 4'd3; b4 = 4'd4; cin4 = 1'b0; v4 = 1'b1;
        #1;
        check("comb_in_reset_s", 64'(s4), 64'd7);

        // Clocks under reset with valid high must not load.
        v1 = 1'b1; a1 = 1'b1;
        tick();
        check("rst_hold_valid", 64'(ov1), 64'd0);
        check("rst_hold_s", 64'(s1), 64'd0);

        @(negedge clk);
        rst_n = 1'b1;

        // Exhaustive 1-bit table, back-to-back.
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            a1 = tv1[i].a; b1 = tv1[i].b; cin1 = tv1[i].cin; v1 = 1'b1;
            tick();
            check($sformatf("w1_s[%0d]", i), 64'(s1), 64'(tv1[i].s));
            check($sformatf("w1_cout[%0d]", i), 64'(co1), 64'(tv1[i].cout));
            check($sformatf("w1_valid[%0d]", i), 64'(ov1), 64'd1);
        end

        // Reset mid-stream clears outputs at once, no clock edge needed.
        @(negedge clk);
        a1 = 1'b1; b1 = 1'b1; cin1 = 1'b1; v1 = 1'b1;
        a8 = 8'd10; b8 = 8'd20; cin8 = 1'b0; v8 = 1'b1;
        tick();
        check("pre_rst_s", 64'(s1), 64'd1);
        check("pre_rst_w8_s", 64'(s8), 64'd30);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_s", 64'(s1), 64'd0);
        check("async_rst_cout", 64'(co1), 64'd0);
        check("async_rst_valid", 64'(ov1), 64'd0);
        check("async_rst_w8_s", 64'(s8), 64'd0);
        check("async_rst_w8_valid", 64'(ov8), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        a1 = 1'b1; b1 = 1'b0; cin1 = 1'b0; v1 = 1'b1;
        v8 = 1'b0;
        #1;
        check("post_rst_nolatch", 64'(ov1), 64'd0);
        tick();
        check("post_rst_s", 64'(s1), 64'd1);
        check("post_rst_valid", 64'(ov1), 64'd1);

        // 8-bit boundaries.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            a8 = tv8[i].a; b8 = tv8[i].b; cin8 = tv8[i].cin; v8 = 1'b1;
            tick();
            check($sformatf("w8_s[%0d]", i), 64'(s8), 64'(tv8[i].s));
            check($sformatf("w8_cout[%0d]", i), 64'(co8), 64'(tv8[i].cout));
            check($sformatf("w8_valid[%0d]", i), 64'(ov8), 64'd1);
        end

        // Valid gating: result held while in_valid is low.
        @(negedge clk);
        a8 = 8'd3; b8 = 8'd4; cin8 = 1'b1; v8 = 1'b1;
        tick();
        check("gate_s_load", 64'(s8), 64'd8);
        check("gate_valid_hi", 64'(ov8), 64'd1);
        @(negedge clk);
        a8 = 8'd9; b8 = 8'd9; v8 = 1'b0;
        tick();
        check("gate_s_held", 64'(s8), 64'd8);
        check("gate_cout_held", 64'(co8), 64'd0);
        check("gate_valid_lo", 64'(ov8), 64'd0);
        tick();
        check("gate_s_held2", 64'(s8), 64'd8);

        // Combinational WIDTH=4: same timestep.
        a4 = 4'hA; b4 = 4'h5; cin4 = 1'b1; v4 = 1'b1;
        #1;
        check("comb_s", 64'(s4), 64'd0);
        check("comb_cout", 64'(co4), 64'd1);
        check("comb_valid", 64'(ov4), 64'd1);
        v4 = 1'b0; a4 = 4'h7; b4 = 4'h2; cin4 = 1'b0;
        #1;
        check("comb_valid_lo", 64'(ov4), 64'd0);
        check("comb_s2", 64'(s4), 64'd9);

        // Random WIDTH=16, back-to-back, occasional idle beats.
        held_s16 = '0;
        held_c16 = 1'b0;
        for (int n = 0; n < 10000; n++) begin
            @(negedge clk);
            a16   = 16'($urandom);
            b16   = 16'($urandom);
            cin16 = 1'($urandom);
            v16   = ($urandom_range(7) != 0);
            exp_v16 = v16;
            if (v16) begin
                exp16    = {1'b0, a16} + {1'b0, b16} + 17'(cin16);
                held_s16 = exp16[15:0];
                held_c16 = exp16[16];
            end
            tick();
            check("rnd_s", 64'(s16), 64'(held_s16));
            check("rnd_cout", 64'(co16), 64'(held_c16));
            check("rnd_valid", 64'(ov16), 64'(exp_v16));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_full_adder
